// File: rtl/ap_mon_pkg.sv
// ap_mon_pkg: shared types, read-select codes and helpers for the ap_ctrl handshake monitor.
//   ch_state_e   : per-channel FSM state (IDLE, RUN, HOLD)
//   SEL_*        : statistic select codes for the readback port
//   MIN_LAT_INIT : "no sample yet" value for min_lat (all ones, sliced to LAT_W by the user)
//   sat_inc      : saturating increment for counters up to 64 bits wide
package ap_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ch_state_e;

    localparam logic [2:0] SEL_TXN   = 3'd0;
    localparam logic [2:0] SEL_RDY   = 3'd1;
    localparam logic [2:0] SEL_LAST  = 3'd2;
    localparam logic [2:0] SEL_MIN   = 3'd3;
    localparam logic [2:0] SEL_MAX   = 3'd4;
    localparam logic [2:0] SEL_STALL = 3'd5;
    localparam logic [2:0] SEL_ACT   = 3'd6;
    localparam logic [2:0] SEL_ERR   = 3'd7;

    localparam logic [63:0] MIN_LAT_INIT = '1;

    // Increment val, sticking at 2^width-1 instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_v;
        if (width >= 64) begin
            max_v = '1;
        end else begin
            max_v = (64'd1 << width) - 64'd1;
        end
        return (val >= max_v) ? max_v : val + 64'd1;
    endfunction

endpackage

// File: rtl/ap_ch_stats.sv
// ap_ch_stats: handshake FSM and statistics for one ap_ctrl_hs / ap_ctrl_chain channel.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   i_ap_start/ready/done   : handshake signals of the monitored block
//   i_ap_continue           : ap_continue (tie high for ap_ctrl_hs)
//   i_freeze                : block all statistic updates this cycle
//   i_clear                 : zero all statistics (wins over any event this cycle)
//   o_busy                  : channel in RUN or HOLD
//   o_*                     : statistic registers
module ap_ch_stats
    import ap_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned LAT_W = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_ap_start,
    input  logic             i_ap_ready,
    input  logic             i_ap_done,
    input  logic             i_ap_continue,
    input  logic             i_freeze,
    input  logic             i_clear,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_txn_count,
    output logic [CNT_W-1:0] o_ready_count,
    output logic [LAT_W-1:0] o_last_lat,
    output logic [LAT_W-1:0] o_min_lat,
    output logic [LAT_W-1:0] o_max_lat,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_active_cycles,
    output logic [CNT_W-1:0] o_err_count
);

    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_INIT = MIN_LAT_INIT[LAT_W-1:0];

    ch_state_e        r_state;
    // Cycles elapsed since the transaction's start cycle; frozen in HOLD at the first-done value.
    logic [LAT_W-1:0] r_lat_cnt;
    logic [CNT_W-1:0] r_txn;
    logic [CNT_W-1:0] r_rdy;
    logic [LAT_W-1:0] r_last;
    logic [LAT_W-1:0] r_min;
    logic [LAT_W-1:0] r_max;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_act;
    logic [CNT_W-1:0] r_err;

    logic             w_complete;
    logic             w_stall;
    logic             w_err;
    logic [LAT_W-1:0] w_lat_sample;

    always_comb begin
        w_complete   = 1'b0;
        w_stall      = 1'b0;
        w_lat_sample = r_lat_cnt;
        unique case (r_state)
            IDLE: begin
                // Start and done together is a zero-latency transaction.
                w_lat_sample = '0;
                if (i_ap_start && i_ap_done) begin
                    w_complete = i_ap_continue;
                    w_stall    = !i_ap_continue;
                end
            end
            RUN: begin
                if (i_ap_done) begin
                    w_complete = i_ap_continue;
                    w_stall    = !i_ap_continue;
                end
            end
            HOLD: begin
                w_complete = i_ap_continue;
                w_stall    = !i_ap_continue;
            end
            default: ;
        endcase
    end

    assign w_err = ((r_state == IDLE) && i_ap_done && !i_ap_start) || (i_ap_ready && !i_ap_start);

    // Channel FSM; keeps tracking regardless of freeze so busy stays accurate.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
        end else if (w_complete) begin
            if (i_ap_start) begin
                r_state   <= RUN;
                r_lat_cnt <= LAT_ONE;
            end else begin
                r_state   <= IDLE;
                r_lat_cnt <= '0;
            end
        end else if (w_stall) begin
            r_state   <= HOLD;
            r_lat_cnt <= w_lat_sample;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_ap_start) begin
                        r_state   <= RUN;
                        r_lat_cnt <= LAT_ONE;
                    end
                end
                RUN:     r_lat_cnt <= LAT_W'(sat_inc(64'(r_lat_cnt), LAT_W));
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_txn   <= '0;
            r_rdy   <= '0;
            r_last  <= '0;
            r_min   <= LAT_INIT;
            r_max   <= '0;
            r_stall <= '0;
            r_act   <= '0;
            r_err   <= '0;
        end else if (!i_freeze) begin
            if (w_complete) begin
                r_txn  <= CNT_W'(sat_inc(64'(r_txn), CNT_W));
                r_last <= w_lat_sample;
                if (w_lat_sample < r_min) r_min <= w_lat_sample;
                if (w_lat_sample > r_max) r_max <= w_lat_sample;
            end
            if (w_stall) r_stall <= CNT_W'(sat_inc(64'(r_stall), CNT_W));
            if (i_ap_start && i_ap_ready) r_rdy <= CNT_W'(sat_inc(64'(r_rdy), CNT_W));
            if (r_state != IDLE) r_act <= CNT_W'(sat_inc(64'(r_act), CNT_W));
            if (w_err) r_err <= CNT_W'(sat_inc(64'(r_err), CNT_W));
        end
    end

    assign o_busy          = (r_state != IDLE);
    assign o_txn_count     = r_txn;
    assign o_ready_count   = r_rdy;
    assign o_last_lat      = r_last;
    assign o_min_lat       = r_min;
    assign o_max_lat       = r_max;
    assign o_stall_cycles  = r_stall;
    assign o_active_cycles = r_act;
    assign o_err_count     = r_err;

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor: per-channel ap_ctrl_hs / ap_ctrl_chain performance monitor.
// Ports:
//   clock, reset                  : clock, synchronous active-high reset
//   i_ap_start/ready/done/continue: per-channel handshake groups (NUM_CH wide)
//   i_finish                      : sets the sticky freeze (effective in the same cycle)
//   i_clear                       : zero all statistics
//   i_rd_en, i_rd_ch, i_rd_sel    : read strobe, channel and statistic select
//   o_rd_data, o_rd_valid         : registered read result, one cycle after i_rd_en
//   o_frozen                      : statistics frozen
//   o_busy                        : per-channel RUN/HOLD indication
module ap_ctrl_perf_monitor
    import ap_mon_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned LAT_W  = 24,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] i_ap_start,
    input  logic [NUM_CH-1:0] i_ap_ready,
    input  logic [NUM_CH-1:0] i_ap_done,
    input  logic [NUM_CH-1:0] i_ap_continue,
    input  logic              i_finish,
    input  logic              i_clear,
    input  logic              i_rd_en,
    input  logic [CH_W-1:0]   i_rd_ch,
    input  logic [2:0]        i_rd_sel,
    output logic [CNT_W-1:0]  o_rd_data,
    output logic              o_rd_valid,
    output logic              o_frozen,
    output logic [NUM_CH-1:0] o_busy
);

    logic             r_frozen;
    logic [CNT_W-1:0] r_rd_data;
    logic             r_rd_valid;

    // The finish cycle itself is already frozen.
    logic             w_freeze;
    logic [CNT_W-1:0] w_rd_mux;

    logic [CNT_W-1:0] w_txn   [NUM_CH];
    logic [CNT_W-1:0] w_rdy   [NUM_CH];
    logic [LAT_W-1:0] w_last  [NUM_CH];
    logic [LAT_W-1:0] w_min   [NUM_CH];
    logic [LAT_W-1:0] w_max   [NUM_CH];
    logic [CNT_W-1:0] w_stall [NUM_CH];
    logic [CNT_W-1:0] w_act   [NUM_CH];
    logic [CNT_W-1:0] w_err   [NUM_CH];

    assign w_freeze = r_frozen || i_finish;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ap_ch_stats #(
            .CNT_W (CNT_W),
            .LAT_W (LAT_W)
        ) u_ch (
            .clock           (clock),
            .reset           (reset),
            .i_ap_start      (i_ap_start[g]),
            .i_ap_ready      (i_ap_ready[g]),
            .i_ap_done       (i_ap_done[g]),
            .i_ap_continue   (i_ap_continue[g]),
            .i_freeze        (w_freeze),
            .i_clear         (i_clear),
            .o_busy          (o_busy[g]),
            .o_txn_count     (w_txn[g]),
            .o_ready_count   (w_rdy[g]),
            .o_last_lat      (w_last[g]),
            .o_min_lat       (w_min[g]),
            .o_max_lat       (w_max[g]),
            .o_stall_cycles  (w_stall[g]),
            .o_active_cycles (w_act[g]),
            .o_err_count     (w_err[g])
        );
    end

    // Out-of-range channels fall through to zero.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_rd_ch == CH_W'(i)) begin
                case (i_rd_sel)
                    SEL_TXN:   w_rd_mux = w_txn[i];
                    SEL_RDY:   w_rd_mux = w_rdy[i];
                    SEL_LAST:  w_rd_mux = CNT_W'(w_last[i]);
                    SEL_MIN:   w_rd_mux = CNT_W'(w_min[i]);
                    SEL_MAX:   w_rd_mux = CNT_W'(w_max[i]);
                    SEL_STALL: w_rd_mux = w_stall[i];
                    SEL_ACT:   w_rd_mux = w_act[i];
                    SEL_ERR:   w_rd_mux = w_err[i];
                    default:   w_rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_frozen   <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (i_finish) r_frozen <= 1'b1;
            r_rd_valid <= i_rd_en;
            if (i_rd_en) r_rd_data <= w_rd_mux;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_frozen   = r_frozen;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
module tb_ap_ctrl_perf_monitor;

    localparam int unsigned NCH  = 3;
    localparam int unsigned CW   = 8;
    localparam int unsigned LW   = 6;
    localparam longint      CMAX = (64'd1 << CW) - 1;
    localparam longint      LMAX = (64'd1 << LW) - 1;

    logic           clock = 1'b0;
    logic           reset;
    logic [NCH-1:0] ap_start, ap_ready, ap_done, ap_cont;
    logic           finish, clear, rd_en;
    logic [1:0]     rd_ch;
    logic [2:0]     rd_sel;
    logic [CW-1:0]  rd_data;
    logic           rd_valid, frozen;
    logic [NCH-1:0] busy;

    // Narrow instance for saturation checks.
    logic [0:0] s_start, s_ready, s_done, s_cont, s_rd_ch, s_busy;
    logic       s_rd_en, s_rd_valid, s_frozen;
    logic [2:0] s_rd_sel;
    logic [3:0] s_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: transaction timestamps and plain-integer statistics.
    longint m_txn [NCH], m_rdy [NCH], m_last [NCH], m_min [NCH], m_max [NCH];
    longint m_stall [NCH], m_act [NCH], m_err [NCH];
    longint m_t0 [NCH], m_td [NCH];
    bit     m_active [NCH], m_hold [NCH];
    bit     m_frozen, m_rd_valid;
    longint m_rd_data;
    longint cyc = 0;

    always #5 clock = ~clock;

    ap_ctrl_perf_monitor #(
        .NUM_CH (NCH),
        .CNT_W  (CW),
        .LAT_W  (LW)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .i_ap_start    (ap_start),
        .i_ap_ready    (ap_ready),
        .i_ap_done     (ap_done),
        .i_ap_continue (ap_cont),
        .i_finish      (finish),
        .i_clear       (clear),
        .i_rd_en       (rd_en),
        .i_rd_ch       (rd_ch),
        .i_rd_sel      (rd_sel),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .o_frozen      (frozen),
        .o_busy        (busy)
    );

    ap_ctrl_perf_monitor #(
        .NUM_CH (1),
        .CNT_W  (4),
        .LAT_W  (4)
    ) u_sat (
        .clock         (clock),
        .reset         (reset),
        .i_ap_start    (s_start),
        .i_ap_ready    (s_ready),
        .i_ap_done     (s_done),
        .i_ap_continue (s_cont),
        .i_finish      (1'b0),
        .i_clear       (1'b0),
        .i_rd_en       (s_rd_en),
        .i_rd_ch       (s_rd_ch),
        .i_rd_sel      (s_rd_sel),
        .o_rd_data     (s_rd_data),
        .o_rd_valid    (s_rd_valid),
        .o_frozen      (s_frozen),
        .o_busy        (s_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        n_checks++;
        if (obs !== expd) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expd, cyc);
        end
    endtask

    function automatic longint sinc(input longint v, input longint mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic zero_stats(input int c);
        m_txn[c] = 0; m_rdy[c] = 0; m_last[c] = 0; m_min[c] = LMAX; m_max[c] = 0;
        m_stall[c] = 0; m_act[c] = 0; m_err[c] = 0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            zero_stats(c);
            m_active[c] = 0; m_hold[c] = 0; m_t0[c] = 0; m_td[c] = 0;
        end
        m_frozen = 0; m_rd_valid = 0; m_rd_data = 0;
    endtask

    function automatic longint model_read(input int ch, input int sel);
        if (ch >= NCH) return 0;
        case (sel)
            0: return m_txn[ch];
            1: return m_rdy[ch];
            2: return m_last[ch];
            3: return m_min[ch];
            4: return m_max[ch];
            5: return m_stall[ch];
            6: return m_act[ch];
            default: return m_err[ch];
        endcase
    endfunction

    function automatic logic [NCH-1:0] model_busy();
        logic [NCH-1:0] b;
        for (int c = 0; c < NCH; c++) b[c] = m_active[c];
        return b;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        if (reset) begin
            model_reset();
        end else begin
            m_rd_valid = rd_en;
            if (rd_en) m_rd_data = model_read(int'(rd_ch), int'(rd_sel));
            for (int c = 0; c < NCH; c++) begin
                bit st, rdy, dn, ct, busy0, hold0, fresh, fin_now, stall_now, err_now;
                longint lat;
                st = ap_start[c]; rdy = ap_ready[c]; dn = ap_done[c]; ct = ap_cont[c];
                busy0 = m_active[c]; hold0 = m_hold[c];
                fresh = !busy0 && st;
                fin_now = 0; stall_now = 0;
                if (fresh) m_t0[c] = cyc;
                if (hold0) begin
                    if (ct) fin_now = 1; else stall_now = 1;
                end else if ((busy0 || fresh) && dn) begin
                    m_td[c] = cyc;
                    m_active[c] = 1;
                    if (ct) fin_now = 1;
                    else begin stall_now = 1; m_hold[c] = 1; end
                end else if (fresh) begin
                    m_active[c] = 1;
                end
                lat = m_td[c] - m_t0[c];
                if (lat > LMAX) lat = LMAX;
                if (fin_now) begin
                    m_hold[c] = 0;
                    m_active[c] = st;
                    if (st) m_t0[c] = cyc;
                end
                err_now = (!busy0 && dn && !st) || (rdy && !st);
                if (clear) begin
                    zero_stats(c);
                end else if (!(m_frozen || finish)) begin
                    if (fin_now) begin
                        m_txn[c] = sinc(m_txn[c], CMAX);
                        m_last[c] = lat;
                        if (lat < m_min[c]) m_min[c] = lat;
                        if (lat > m_max[c]) m_max[c] = lat;
                    end
                    if (stall_now) m_stall[c] = sinc(m_stall[c], CMAX);
                    if (st && rdy) m_rdy[c] = sinc(m_rdy[c], CMAX);
                    if (busy0) m_act[c] = sinc(m_act[c], CMAX);
                    if (err_now) m_err[c] = sinc(m_err[c], CMAX);
                end
            end
            if (finish) m_frozen = 1;
        end
        cyc++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_eq("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
        check_eq("rd_data", 64'(rd_data), 64'(m_rd_data));
        check_eq("busy", 64'(busy), 64'(model_busy()));
        check_eq("frozen", 64'(frozen), 64'(m_frozen));
    endtask

    task automatic idle_inputs();
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_cont = '1;
        finish = 0; clear = 0; rd_en = 0; rd_ch = '0; rd_sel = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; tick(); tick(); reset = 0;
    endtask

    task automatic expect_stat(input string tag, input int ch, input int sel, input longint val);
        rd_en = 1; rd_ch = 2'(ch); rd_sel = 3'(sel);
        tick();
        check_eq({tag, "_valid"}, 64'(rd_valid), 64'd1);
        check_eq(tag, 64'(rd_data), 64'(val));
        rd_en = 0;
    endtask

    // One ap_ctrl_hs transaction on channel c with the given start-to-done latency (>= 1).
    task automatic simple_txn(input int c, input int lat);
        ap_start[c] = 1; ap_ready[c] = 1; tick();
        ap_start[c] = 0; ap_ready[c] = 0;
        repeat (lat - 1) tick();
        ap_done[c] = 1; tick();
        ap_done[c] = 0;
    endtask

    task automatic rand_inputs();
        for (int c = 0; c < NCH; c++) begin
            ap_start[c] = ($urandom_range(0, 3) == 0);
            ap_ready[c] = ap_start[c] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 63) == 0);
            if (m_hold[c]) ap_done[c] = 1;
            else if (m_active[c]) ap_done[c] = (c == 2) ? ($urandom_range(0, 79) == 0)
                                                         : ($urandom_range(0, 4) == 0);
            else ap_done[c] = ($urandom_range(0, 31) == 0);
            ap_cont[c] = (c == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
        clear  = ($urandom_range(0, 199) == 0);
        rd_en  = ($urandom_range(0, 2) == 0);
        rd_ch  = 2'($urandom_range(0, 3));
        rd_sel = 3'($urandom_range(0, 7));
    endtask

    task automatic sat_read(input string tag, input int sel, input longint val);
        s_rd_en = 1; s_rd_sel = 3'(sel); tick();
        check_eq({tag, "_valid"}, 64'(s_rd_valid), 64'd1);
        check_eq(tag, 64'(s_rd_data), 64'(val));
        s_rd_en = 0;
    endtask

    initial begin
        int fin_at;
        s_start = '0; s_ready = '0; s_done = '0; s_cont = '1; s_rd_ch = '0;
        s_rd_en = 0; s_rd_sel = '0;
        model_reset();
        do_reset();

        // Reset state.
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_frozen", 64'(frozen), 64'd0);
        check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("rst_rd_data", 64'(rd_data), 64'd0);
        for (int s = 0; s < 8; s++) expect_stat("rst_stat", 0, s, (s == 3) ? LMAX : 0);

        // Single transaction, latency 5.
        tick();
        simple_txn(0, 5);
        rd_en = 1; rd_ch = 2'd0; rd_sel = 3'd0;
        check_eq("rdv_before", 64'(rd_valid), 64'd0);
        tick(); rd_en = 0;
        check_eq("single_txn", 64'(rd_data), 64'd1);
        check_eq("rdv_after", 64'(rd_valid), 64'd1);
        expect_stat("single_last", 0, 2, 5);
        expect_stat("single_min", 0, 3, 5);
        expect_stat("single_max", 0, 4, 5);
        check_eq("rdv_pulse", 64'(rd_valid), 64'd1);
        tick();
        check_eq("rdv_drop", 64'(rd_valid), 64'd0);

        // Backpressure on ch1: done after 10 cycles, continue low for 4 cycles.
        ap_start[1] = 1; ap_ready[1] = 1; tick();
        ap_start[1] = 0; ap_ready[1] = 0;
        repeat (9) tick();
        ap_done[1] = 1; ap_cont[1] = 0; tick();
        repeat (3) tick();
        check_eq("bp_busy_hold", 64'(busy[1]), 64'd1);
        ap_cont[1] = 1; tick();
        ap_done[1] = 0;
        check_eq("bp_busy_done", 64'(busy[1]), 64'd0);
        expect_stat("bp_stall", 1, 5, 4);
        expect_stat("bp_last", 1, 2, 10);
        expect_stat("bp_txn", 1, 0, 1);

        // Back-to-back on ch0: latencies 3, 7, 2 with start held.
        do_reset();
        ap_start[0] = 1; ap_ready[0] = 1; tick();
        ap_ready[0] = 0; tick(); tick();
        ap_done[0] = 1; ap_ready[0] = 1; tick();
        ap_done[0] = 0; ap_ready[0] = 0; repeat (6) tick();
        ap_done[0] = 1; ap_ready[0] = 1; tick();
        ap_done[0] = 0; ap_ready[0] = 0; tick();
        ap_start[0] = 0; ap_done[0] = 1; tick();
        ap_done[0] = 0;
        expect_stat("b2b_txn", 0, 0, 3);
        expect_stat("b2b_min", 0, 3, 2);
        expect_stat("b2b_max", 0, 4, 7);
        expect_stat("b2b_last", 0, 2, 2);
        expect_stat("b2b_ready", 0, 1, 3);
        expect_stat("b2b_err", 0, 7, 0);

        // Stray done in IDLE.
        ap_done[2] = 1; tick(); ap_done[2] = 0;
        expect_stat("err_done_idle", 2, 7, 1);

        // Clear coincident with a completing done.
        ap_start[0] = 1; ap_ready[0] = 1; tick();
        ap_start[0] = 0; ap_ready[0] = 0; tick();
        ap_done[0] = 1; clear = 1; tick();
        ap_done[0] = 0; clear = 0;
        expect_stat("clr_txn", 0, 0, 0);
        expect_stat("clr_min", 0, 3, LMAX);
        expect_stat("clr_max", 0, 4, 0);
        expect_stat("clr_err", 2, 7, 0);

        // Freeze: finish coincident with a done, then one more transaction.
        simple_txn(0, 2);
        ap_start[0] = 1; ap_ready[0] = 1; tick();
        ap_start[0] = 0; ap_ready[0] = 0; tick();
        ap_done[0] = 1; finish = 1; tick();
        ap_done[0] = 0; finish = 0;
        check_eq("frz_flag", 64'(frozen), 64'd1);
        simple_txn(0, 3);
        expect_stat("frz_txn", 0, 0, 1);
        expect_stat("frz_last", 0, 2, 2);
        check_eq("frz_sticky", 64'(frozen), 64'd1);

        // Reset mid-transaction, then a fresh 4-cycle transaction.
        do_reset();
        check_eq("rst_unfrozen", 64'(frozen), 64'd0);
        ap_start[0] = 1; ap_ready[0] = 1; tick();
        ap_start[0] = 0; ap_ready[0] = 0; tick();
        reset = 1; tick(); reset = 0;
        check_eq("rst_abort_busy", 64'(busy[0]), 64'd0);
        simple_txn(0, 4);
        expect_stat("rst_txn", 0, 0, 1);
        expect_stat("rst_last", 0, 2, 4);
        expect_stat("bad_ch", 3, 0, 0);

        // Randomized traffic, first without and then with a finish.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            rand_inputs();
            tick();
        end
        fin_at = int'($urandom_range(100, 400));
        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            finish = (n >= fin_at) && (n < fin_at + 3);
            tick();
        end
        idle_inputs();

        // Saturation on the narrow instance.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            s_start = '1; s_ready = '1; tick();
            s_start = '0; s_ready = '0; s_done = '1; tick();
            s_done = '0;
        end
        sat_read("sat_txn", 0, 15);
        sat_read("sat_min", 3, 1);
        s_start = '1; tick(); s_start = '0;
        repeat (19) tick();
        s_done = '1; tick(); s_done = '0;
        sat_read("sat_last", 2, 15);
        sat_read("sat_act", 6, 15);
        sat_read("sat_txn_hold", 0, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
